dual_issue_scheduler: RTL
=========================

Name: dual_issue_scheduler

Overview:
Sits between the instruction Decoder and the even/odd execution pipes of the SPU. It accepts one decoded instruction pair (slot 0 = older, slot 1 = younger) and issues each instruction to its pipe in program order. It tracks in-flight destination registers in a latency scoreboard. It back-pressures the Decoder through stallOut when it is holding work it cannot issue.

Parameters:
addrWidth, 7, register address width (128-entry register file)
opWidth, 6, opcode width per slot
latWidth, 3, result-latency field width (max 7 cycles)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
pairValid  in  1  Decoder presents a pair this cycle
stallIn  in  1  downstream pipes frozen
flush  in  1  synchronous kill of held/unissued instructions
opIn[2]  in  2x opWidth  opcode per slot
raIn[2], rbIn[2], rcIn[2], rdIn[2]  in  2x addrWidth each  register addresses per slot
useRaIn[2], useRbIn[2], useRcIn[2]  in  2x1 each  source is read
wrRdIn[2]  in  2x1  slot writes rd
pipeIn[2]  in  2x1  0 = even, 1 = odd
latIn[2]  in  2x latWidth  cycles until result is readable (0 = no hazard)
stallOut  out  1  pair not accepted this cycle
issueValid[2]  out  2x1  index 0 = even pipe, 1 = odd pipe
opOut[2], raOut[2], rbOut[2], rcOut[2], rdOut[2], wrOut[2]  out  per pipe  registered issued fields

Behaviour:
- Reset (reset=0, asynchronous): state EMPTY; hold registers, all scoreboard counters and all outputs are 0; stallOut=1 while reset is asserted and 0 in the first cycle after release.
- States:
  - EMPTY: nothing held.
  - PAIR: both slots held.
  - HALF: only slot 1 held.
- Accept: when pairValid=1 and stallOut=0, the pair is latched at the clock edge and the state becomes PAIR.
- stallOut is combinational: 0 iff the state is EMPTY, or every held instruction issues this cycle and stallIn=0. This permits back-to-back pairs at full throughput.
- Hazard, per instruction:
  - any used source with cnt[src] != 0, or
  - wrRd=1 with cnt[rd] != 0 (WAW).
- PAIR issue rules, evaluated combinationally each cycle with stallIn=0:
  - Slot 0 hazard: nothing issues; stay in PAIR (in-order).
  - Slot 0 clear, and slot 1 is clear, pipeIn differs, slot 1 sources do not match slot 0 rd (when slot 0 wrRd=1), and rd values are not equal when both write: both issue; state becomes EMPTY or PAIR (new pair accepted).
  - Otherwise: slot 0 issues alone; state becomes HALF.
- HALF: slot 1 issues when hazard-free, then the state becomes EMPTY or PAIR. Otherwise stay in HALF.
- Outputs are registered, 1-cycle latency from the decision. issueValid is driven on the pipe index given by pipeIn, and the unissued pipe's valid is 0.
- Scoreboard: one latWidth-bit counter per register. Each cycle with stallIn=0, every nonzero counter decrements by 1. On issue with wrRd=1 and lat>0, cnt[rd] <= lat; a load and a decrement in the same cycle resolve to the load.
- stallIn=1: no issue, no accept; output registers and counters hold their values.
- flush=1: highest priority after reset.
  - Hold registers are cleared; state becomes EMPTY; next-cycle issueValid=0.
  - The pair on the inputs is not accepted.
  - Scoreboard counters keep running (already-issued ops remain in flight).
- Register 0 is not special; all 128 registers are tracked.

Decomposition:
- Package spu_issue_pkg:
  - pipe_e {PIPE_EVEN, PIPE_ODD}
  - state_e {EMPTY, PAIR, HALF}
  - slot_t struct (op, ra/rb/rc/rd, use bits, wrRd, pipe, lat)
  - width constants
- Sub-module issue_scoreboard: holds the counter array. Interface: two hazard-query ports (each with 3 sources and rd), two set ports (rd, lat, en), and a freeze input driven by stallIn.

Test Plan:
- Independent pair: slot 0 even rd=5 lat=2, slot 1 odd rd=6 -> both valid on the next cycle, stallOut=0 throughout.
- Same pipe: both slots even -> slot 0 issues in cycle 1, slot 1 in cycle 2; stallOut=1 for exactly 1 cycle.
- Intra-pair RAW: slot 0 rd=10 lat=4, slot 1 ra=10 useRa -> slot 0 issues; slot 1 issues after 4 cycles (cnt[10] reaches 0).
- Slot 0 reads a busy register (cnt=3): no issue for 3 cycles, then both issue together; the decoder is stalled for 3 cycles.
- stallIn pulsed high for 2 cycles during HALF -> outputs and counters frozen; issue resumes with unchanged timing offset.
- Flush in HALF with cnt[10]=2 -> next-cycle issueValid=0, state EMPTY; cnt[10] still reaches 0 two cycles later; async reset mid-PAIR clears everything immediately.

Source files
------------

// File: rtl/spu_issue_pkg.sv
// Shared types and widths for the SPU dual-issue scheduler.
package spu_issue_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned LAT_W  = 3;

    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;

    typedef enum logic [1:0] {EMPTY, PAIR, HALF} state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [ADDR_W-1:0] rd;
        logic              useRa;
        logic              useRb;
        logic              useRc;
        logic              wrRd;
        pipe_e             pipe;
        logic [LAT_W-1:0]  lat;
    } slot_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register result-latency counters with two hazard queries and two set ports.
module issue_scoreboard
    import spu_issue_pkg::*;
#(
    parameter int unsigned addrWidth = ADDR_W,
    parameter int unsigned latWidth  = LAT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic [addrWidth-1:0] qRa [2],
    input  logic [addrWidth-1:0] qRb [2],
    input  logic [addrWidth-1:0] qRc [2],
    input  logic [addrWidth-1:0] qRd [2],
    input  logic                 qUseRa [2],
    input  logic                 qUseRb [2],
    input  logic                 qUseRc [2],
    input  logic                 qWrRd [2],
    output logic                 hazard [2],
    input  logic                 setEn [2],
    input  logic [addrWidth-1:0] setRd [2],
    input  logic [latWidth-1:0]  setLat [2]
);

    localparam int unsigned numRegs = 1 << addrWidth;

    logic [latWidth-1:0] cnt [numRegs];

    always_comb begin
        for (int unsigned q = 0; q < 2; q++) begin
            hazard[q] = (qUseRa[q] && cnt[qRa[q]] != '0) ||
                        (qUseRb[q] && cnt[qRb[q]] != '0) ||
                        (qUseRc[q] && cnt[qRc[q]] != '0) ||
                        (qWrRd[q]  && cnt[qRd[q]] != '0);
        end
    end

    // A load wins over the decrement in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < numRegs; r++) cnt[r] <= '0;
        end else if (!freeze) begin
            for (int unsigned r = 0; r < numRegs; r++) begin
                if (setEn[0] && setRd[0] == addrWidth'(r))
                    cnt[r] <= setLat[0];
                else if (setEn[1] && setRd[1] == addrWidth'(r))
                    cnt[r] <= setLat[1];
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Holds one decoded pair and issues it in order to the even/odd SPU pipes.
module dual_issue_scheduler
    import spu_issue_pkg::*;
#(
    parameter int unsigned addrWidth = ADDR_W,
    parameter int unsigned opWidth   = OP_W,
    parameter int unsigned latWidth  = LAT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pairValid,
    input  logic                 stallIn,
    input  logic                 flush,
    input  logic [opWidth-1:0]   opIn [2],
    input  logic [addrWidth-1:0] raIn [2],
    input  logic [addrWidth-1:0] rbIn [2],
    input  logic [addrWidth-1:0] rcIn [2],
    input  logic [addrWidth-1:0] rdIn [2],
    input  logic                 useRaIn [2],
    input  logic                 useRbIn [2],
    input  logic                 useRcIn [2],
    input  logic                 wrRdIn [2],
    input  logic                 pipeIn [2],
    input  logic [latWidth-1:0]  latIn [2],
    output logic                 stallOut,
    output logic                 issueValid [2],
    output logic [opWidth-1:0]   opOut [2],
    output logic [addrWidth-1:0] raOut [2],
    output logic [addrWidth-1:0] rbOut [2],
    output logic [addrWidth-1:0] rcOut [2],
    output logic [addrWidth-1:0] rdOut [2],
    output logic                 wrOut [2]
);

    state_e state;
    slot_t  hold [2];
    slot_t  inSlot [2];
    logic   hazard [2];
    logic   issue [2];
    logic   dst [2];
    logic   setEn [2];
    logic [addrWidth-1:0] qRa [2], qRb [2], qRc [2], qRd [2], setRd [2];
    logic                 qUseRa [2], qUseRb [2], qUseRc [2], qWrRd [2];
    logic [latWidth-1:0]  setLat [2];
    logic srcHit, pairOk, canIssue, allIssue, accept;

    issue_scoreboard #(.addrWidth(addrWidth), .latWidth(latWidth)) sb (
        .clk(clk), .reset(reset), .freeze(stallIn),
        .qRa(qRa), .qRb(qRb), .qRc(qRc), .qRd(qRd),
        .qUseRa(qUseRa), .qUseRb(qUseRb), .qUseRc(qUseRc), .qWrRd(qWrRd),
        .hazard(hazard), .setEn(setEn), .setRd(setRd), .setLat(setLat)
    );

    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            inSlot[s] = '{op: opIn[s], ra: raIn[s], rb: rbIn[s], rc: rcIn[s], rd: rdIn[s],
                          useRa: useRaIn[s], useRb: useRbIn[s], useRc: useRcIn[s],
                          wrRd: wrRdIn[s], pipe: pipe_e'(pipeIn[s]), lat: latIn[s]};
            qRa[s] = hold[s].ra;  qUseRa[s] = hold[s].useRa;
            qRb[s] = hold[s].rb;  qUseRb[s] = hold[s].useRb;
            qRc[s] = hold[s].rc;  qUseRc[s] = hold[s].useRc;
            qRd[s] = hold[s].rd;  qWrRd[s]  = hold[s].wrRd;
            dst[s] = (hold[s].pipe == PIPE_ODD);
        end
        srcHit = hold[0].wrRd && ((hold[1].useRa && hold[1].ra == hold[0].rd) ||
                                  (hold[1].useRb && hold[1].rb == hold[0].rd) ||
                                  (hold[1].useRc && hold[1].rc == hold[0].rd));
        pairOk = !hazard[1] && (hold[0].pipe != hold[1].pipe) && !srcHit &&
                 !(hold[0].wrRd && hold[1].wrRd && hold[0].rd == hold[1].rd);
        canIssue = !stallIn && !flush;
        issue[0] = canIssue && state == PAIR && !hazard[0];
        issue[1] = canIssue && ((state == PAIR && !hazard[0] && pairOk) ||
                                (state == HALF && !hazard[1]));
        allIssue = (state == PAIR) ? (issue[0] && issue[1]) : issue[1];
        // stallIn also guards the EMPTY case so a frozen cycle never drops a pair.
        stallOut = !reset || stallIn || !(state == EMPTY || allIssue);
        accept   = pairValid && !stallOut && !flush;
        for (int unsigned s = 0; s < 2; s++) begin
            setEn[s]  = issue[s] && hold[s].wrRd && hold[s].lat != '0;
            setRd[s]  = hold[s].rd;
            setLat[s] = hold[s].lat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            for (int unsigned s = 0; s < 2; s++) begin
                hold[s]       <= '0;
                issueValid[s] <= 1'b0;
                opOut[s]      <= '0;
                raOut[s]      <= '0;
                rbOut[s]      <= '0;
                rcOut[s]      <= '0;
                rdOut[s]      <= '0;
                wrOut[s]      <= 1'b0;
            end
        end else if (flush) begin
            state <= EMPTY;
            for (int unsigned s = 0; s < 2; s++) begin
                hold[s]       <= '0;
                issueValid[s] <= 1'b0;
            end
        end else if (!stallIn) begin
            for (int unsigned s = 0; s < 2; s++) issueValid[s] <= 1'b0;
            for (int unsigned s = 0; s < 2; s++) begin
                if (issue[s]) begin
                    issueValid[dst[s]] <= 1'b1;
                    opOut[dst[s]]      <= hold[s].op;
                    raOut[dst[s]]      <= hold[s].ra;
                    rbOut[dst[s]]      <= hold[s].rb;
                    rcOut[dst[s]]      <= hold[s].rc;
                    rdOut[dst[s]]      <= hold[s].rd;
                    wrOut[dst[s]]      <= hold[s].wrRd;
                end
            end
            unique case (state)
                EMPTY: if (accept) state <= PAIR;
                PAIR: begin
                    if (issue[1])      state <= accept ? PAIR : EMPTY;
                    else if (issue[0]) state <= HALF;
                end
                HALF: if (issue[1]) state <= accept ? PAIR : EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                hold[0] <= inSlot[0];
                hold[1] <= inSlot[1];
            end else if (issue[0] && !issue[1]) begin
                hold[0] <= '0;
            end
        end
    end

endmodule
